// File: rtl/dp_ctrl_pkg.sv
// Shared types and encodings for the datapath control sequencer.
package dp_ctrl_pkg;

    // One state per micro-step of the multicycle instruction flow.
    typedef enum logic [4:0] {
        StRst,
        StIf1,
        StIf2,
        StUpc,
        StDec,
        StMovi,
        StGeta,
        StGetb,
        StExec,
        StWb,
        StAddr,
        StLaddr,
        StRd1,
        StRd2,
        StSgetb,
        StSpass,
        StWr,
        StHalt
    } dp_state_t;

    // Opcode field ir[15:13]
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Op field ir[12:11]
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;

    // Memory command encodings
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Writeback mux select encodings
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Bundle of every registered control output.
    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       shift_ctrl;
        logic [1:0] vsel;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{load_pc: 1'b1, reset_pc: 1'b1, default: '0};

endpackage

// File: rtl/dp_decoder.sv
// Combinational instruction field split, sign extension and class flags.
module dp_decoder
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] ir,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [2:0]   rm,
    output logic [1:0]   op,
    output logic [1:0]   sh,
    output logic [W-1:0] sximm8,
    output logic [W-1:0] sximm5,
    output logic         is_movi,
    output logic         is_movr,
    output logic         is_mvn,
    output logic         is_cmp,
    output logic         is_ldr,
    output logic         is_str,
    output logic         is_halt
);

    logic [2:0] opcode;
    logic       is_alu;

    // Field split and immediate sign extension
    always_comb begin
        opcode = ir[15:13];
        op     = ir[12:11];
        rn     = ir[10:8];
        rd     = ir[7:5];
        sh     = ir[4:3];
        rm     = ir[2:0];
        sximm8 = {{(W-8){ir[7]}}, ir[7:0]};
        sximm5 = {{(W-5){ir[4]}}, ir[4:0]};
    end

    // Instruction class flags; anything not recognised is treated as HALT
    always_comb begin
        is_alu  = (opcode == OPC_ALU);
        is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
        is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
        is_mvn  = is_alu && (op == OP_MVN);
        is_cmp  = is_alu && (op == OP_CMP);
        is_ldr  = (opcode == OPC_LDR) && (op == 2'b00);
        is_str  = (opcode == OPC_STR) && (op == 2'b00);
        is_halt = !(is_alu || is_movi || is_movr || is_ldr || is_str);
    end

endmodule

// File: rtl/dp_sequencer.sv
// Multicycle control FSM driving the 16-bit datapath and memory command.
module dp_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] ir,
    output logic         load_ir,
    output logic         load_pc,
    output logic         reset_pc,
    output logic         load_addr,
    output logic         addr_sel,
    output logic [1:0]   mem_cmd,
    output logic         loada,
    output logic         loadb,
    output logic         loadc,
    output logic         loads,
    output logic         write,
    output logic         asel,
    output logic         bsel,
    output logic         shift_ctrl,
    output logic [1:0]   vsel,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic [1:0]   shift,
    output logic [1:0]   ALUop,
    output logic [W-1:0] sximm8,
    output logic [W-1:0] sximm5,
    output logic         halted
);

    logic [2:0] rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_movi, is_movr, is_mvn, is_cmp, is_ldr, is_str, is_halt;

    dp_state_t state_q, state_d;
    ctrl_t     ctrl_q, ctrl_d;

    dp_decoder #(
        .W(W)
    ) u_decoder (
        .ir     (ir),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .op     (op),
        .sh     (sh),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .is_movi(is_movi),
        .is_movr(is_movr),
        .is_mvn (is_mvn),
        .is_cmp (is_cmp),
        .is_ldr (is_ldr),
        .is_str (is_str),
        .is_halt(is_halt)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:   state_d = StIf1;
            StIf1:   state_d = StIf2;
            StIf2:   state_d = StUpc;
            StUpc:   state_d = StDec;
            StDec: begin
                if (is_halt)                state_d = StHalt;
                else if (is_movi)           state_d = StMovi;
                else if (is_movr || is_mvn) state_d = StGetb;
                else                        state_d = StGeta;
            end
            StMovi:  state_d = StIf1;
            StGeta:  state_d = (is_ldr || is_str) ? StAddr : StGetb;
            StGetb:  state_d = StExec;
            StExec:  state_d = is_cmp ? StIf1 : StWb;
            StWb:    state_d = StIf1;
            StAddr:  state_d = StLaddr;
            StLaddr: state_d = is_ldr ? StRd1 : StSgetb;
            StRd1:   state_d = StRd2;
            StRd2:   state_d = StIf1;
            StSgetb: state_d = StSpass;
            StSpass: state_d = StWr;
            StWr:    state_d = StIf1;
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    // Moore output decode of the state being entered, so outputs can be registered
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            StRst: ctrl_d = CTRL_RST;
            StIf1: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_cmd  = MEM_READ;
            end
            StIf2: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_cmd  = MEM_READ;
                ctrl_d.load_ir  = 1'b1;
            end
            StUpc: ctrl_d.load_pc = 1'b1;
            StDec: ctrl_d = '0;
            StMovi: begin
                ctrl_d.writenum = rn;
                ctrl_d.vsel     = VSEL_IMM8;
                ctrl_d.write    = 1'b1;
            end
            StGeta: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            StGetb: begin
                ctrl_d.readnum = rm;
                ctrl_d.loadb   = 1'b1;
            end
            StExec: begin
                ctrl_d.shift  = sh;
                ctrl_d.alu_op = is_movr ? 2'b00 : op;
                ctrl_d.asel   = is_movr || is_mvn;
                ctrl_d.loads  = is_cmp;
                ctrl_d.loadc  = !is_cmp;
            end
            StWb: begin
                ctrl_d.writenum = rd;
                ctrl_d.vsel     = VSEL_C;
                ctrl_d.write    = 1'b1;
            end
            StAddr: begin
                ctrl_d.bsel       = 1'b1;
                ctrl_d.shift_ctrl = 1'b1;
                ctrl_d.loadc      = 1'b1;
            end
            StLaddr: ctrl_d.load_addr = 1'b1;
            StRd1: ctrl_d.mem_cmd = MEM_READ;
            StRd2: begin
                ctrl_d.mem_cmd  = MEM_READ;
                ctrl_d.vsel     = VSEL_MDATA;
                ctrl_d.writenum = rd;
                ctrl_d.write    = 1'b1;
            end
            StSgetb: begin
                ctrl_d.readnum = rd;
                ctrl_d.loadb   = 1'b1;
            end
            StSpass: begin
                // A = 0 (asel) so the ALU passes the store data through unchanged
                ctrl_d.asel       = 1'b1;
                ctrl_d.shift_ctrl = 1'b1;
                ctrl_d.loadc      = 1'b1;
            end
            StWr: ctrl_d.mem_cmd = MEM_WRITE;
            StHalt: ctrl_d.halted = 1'b1;
            default: ctrl_d.halted = 1'b1;
        endcase
    end

    // State and registered outputs; reset wins from any state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRst;
            ctrl_q  <= CTRL_RST;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Output fan-out from the control register
    always_comb begin
        load_ir    = ctrl_q.load_ir;
        load_pc    = ctrl_q.load_pc;
        reset_pc   = ctrl_q.reset_pc;
        load_addr  = ctrl_q.load_addr;
        addr_sel   = ctrl_q.addr_sel;
        mem_cmd    = ctrl_q.mem_cmd;
        loada      = ctrl_q.loada;
        loadb      = ctrl_q.loadb;
        loadc      = ctrl_q.loadc;
        loads      = ctrl_q.loads;
        write      = ctrl_q.write;
        asel       = ctrl_q.asel;
        bsel       = ctrl_q.bsel;
        shift_ctrl = ctrl_q.shift_ctrl;
        vsel       = ctrl_q.vsel;
        readnum    = ctrl_q.readnum;
        writenum   = ctrl_q.writenum;
        shift      = ctrl_q.shift;
        ALUop      = ctrl_q.alu_op;
        halted     = ctrl_q.halted;
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed scoreboard bench: per-cycle expected control vectors are queued
// when an instruction is issued and compared as the sequencer steps.
module tb_dp_sequencer;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       shift_ctrl;
        logic [1:0] vsel;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       halted;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic        load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [1:0]  mem_cmd;
    logic        loada, loadb, loadc, loads, write, asel, bsel, shift_ctrl;
    logic [1:0]  vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;
    logic        halted;

    int n_cmp  = 0;
    int n_fail = 0;

    ctl_t  exp_q[$];
    string tag_q[$];

    dp_sequencer #(
        .W(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_addr (load_addr),
        .addr_sel  (addr_sel),
        .mem_cmd   (mem_cmd),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .write     (write),
        .asel      (asel),
        .bsel      (bsel),
        .shift_ctrl(shift_ctrl),
        .vsel      (vsel),
        .readnum   (readnum),
        .writenum  (writenum),
        .shift     (shift),
        .ALUop     (ALUop),
        .sximm8    (sximm8),
        .sximm5    (sximm5),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t observed();
        ctl_t c;
        c.load_ir    = load_ir;
        c.load_pc    = load_pc;
        c.reset_pc   = reset_pc;
        c.load_addr  = load_addr;
        c.addr_sel   = addr_sel;
        c.mem_cmd    = mem_cmd;
        c.loada      = loada;
        c.loadb      = loadb;
        c.loadc      = loadc;
        c.loads      = loads;
        c.write      = write;
        c.asel       = asel;
        c.bsel       = bsel;
        c.shift_ctrl = shift_ctrl;
        c.vsel       = vsel;
        c.readnum    = readnum;
        c.writenum   = writenum;
        c.shift      = shift;
        c.aluop      = ALUop;
        c.halted     = halted;
        return c;
    endfunction

    task automatic push(input string tag, input ctl_t c);
        tag_q.push_back(tag);
        exp_q.push_back(c);
    endtask

    // Pop one expected vector and compare at the falling edge
    task automatic check_one();
        ctl_t  e;
        ctl_t  o;
        string t;
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", t, o, e);
        end
    endtask

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Drain the queue; the new instruction is presented once IF1 has been seen
    task automatic run(input logic [15:0] v);
        bit first = 1'b1;
        while (exp_q.size() > 0) begin
            check_one();
            if (first) begin
                ir    = v;
                first = 1'b0;
            end
        end
    endtask

    task automatic push_rst();
        ctl_t c = '0;
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
        push("RST", c);
    endtask

    task automatic push_fetch();
        ctl_t c = '0;
        c.addr_sel = 1'b1;
        c.mem_cmd  = 2'b01;
        push("IF1", c);
        c.load_ir = 1'b1;
        push("IF2", c);
        c = '0;
        c.load_pc = 1'b1;
        push("UPC", c);
        c = '0;
        push("DEC", c);
    endtask

    task automatic push_reg(input string tag, input logic [2:0] r, input bit a_side);
        ctl_t c = '0;
        c.readnum = r;
        if (a_side) c.loada = 1'b1;
        else        c.loadb = 1'b1;
        push(tag, c);
    endtask

    task automatic push_exec(input logic [1:0] sh, input logic [1:0] alu, input bit a0, input bit cmp);
        ctl_t c = '0;
        c.shift = sh;
        c.aluop = alu;
        c.asel  = a0;
        c.loads = cmp;
        c.loadc = !cmp;
        push("EXEC", c);
    endtask

    task automatic push_write(input string tag, input logic [2:0] r, input logic [1:0] vs,
                              input logic [1:0] mc);
        ctl_t c = '0;
        c.writenum = r;
        c.vsel     = vs;
        c.write    = 1'b1;
        c.mem_cmd  = mc;
        push(tag, c);
    endtask

    task automatic push_addr();
        ctl_t c = '0;
        c.bsel       = 1'b1;
        c.shift_ctrl = 1'b1;
        c.loadc      = 1'b1;
        push("ADDR", c);
        c = '0;
        c.load_addr = 1'b1;
        push("LADDR", c);
    endtask

    task automatic push_halt(input int n);
        ctl_t c = '0;
        c.halted = 1'b1;
        for (int i = 0; i < n; i++) push("HALT", c);
    endtask

    initial begin
        ctl_t c;
        rst_n = 1'b0;
        ir    = 16'h0000;
        repeat (2) @(posedge clk);
        push_rst();
        check_one();
        rst_n = 1'b1;

        // MOV R1,#5
        push_fetch();
        push_write("MOVI", 3'd1, 2'b10, 2'b00);
        run(16'hD105);
        check_val("sximm8_movi", sximm8, 16'h0005);

        // ADD R6,R0,R2
        push_fetch();
        push_reg("GETA", 3'd0, 1'b1);
        push_reg("GETB", 3'd2, 1'b0);
        push_exec(2'b00, 2'b00, 1'b0, 1'b0);
        push_write("WB", 3'd6, 2'b00, 2'b00);
        run(16'hA0C2);

        // CMP R1,R2: status only, no writeback
        push_fetch();
        push_reg("GETA", 3'd1, 1'b1);
        push_reg("GETB", 3'd2, 1'b0);
        push_exec(2'b00, 2'b01, 1'b0, 1'b1);
        run(16'hA9E2);

        // MVN R6,R1
        push_fetch();
        push_reg("GETB", 3'd1, 1'b0);
        push_exec(2'b00, 2'b11, 1'b1, 1'b0);
        push_write("WB", 3'd6, 2'b00, 2'b00);
        run(16'hB8C1);

        // MOV R3,R4,LSL#1
        push_fetch();
        push_reg("GETB", 3'd4, 1'b0);
        push_exec(2'b01, 2'b00, 1'b1, 1'b0);
        push_write("WB", 3'd3, 2'b00, 2'b00);
        run(16'hC06C);

        // LDR R0,[R1,#-1]
        push_fetch();
        push_reg("GETA", 3'd1, 1'b1);
        push_addr();
        c = '0;
        c.mem_cmd = 2'b01;
        push("RD1", c);
        push_write("RD2", 3'd0, 2'b11, 2'b01);
        run(16'h611F);
        check_val("sximm5_ldr", sximm5, 16'hFFFF);
        check_val("sximm8_ldr", sximm8, 16'h001F);

        // STR R2,[R1,#0], full run
        push_fetch();
        push_reg("GETA", 3'd1, 1'b1);
        push_addr();
        push_reg("SGETB", 3'd2, 1'b0);
        c = '0;
        c.asel       = 1'b1;
        c.shift_ctrl = 1'b1;
        c.loadc      = 1'b1;
        push("SPASS", c);
        c = '0;
        c.mem_cmd = 2'b10;
        push("WR", c);
        run(16'h8140);
        check_val("sximm5_str", sximm5, 16'h0000);

        // STR again, reset asserted in SPASS: no WRITE may follow
        push_fetch();
        push_reg("GETA", 3'd1, 1'b1);
        push_addr();
        push_reg("SGETB", 3'd2, 1'b0);
        c = '0;
        c.asel       = 1'b1;
        c.shift_ctrl = 1'b1;
        c.loadc      = 1'b1;
        push("SPASS", c);
        run(16'h8140);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) push_rst();
        run(16'h8140);
        rst_n = 1'b1;

        // HALT held
        push_fetch();
        push_halt(20);
        run(16'hE000);

        // Reset out of HALT, then an illegal encoding also halts
        rst_n = 1'b0;
        push_rst();
        check_one();
        rst_n = 1'b1;
        push_fetch();
        push_halt(4);
        run(16'h0000);
        check_val("sximm8_neg", sximm8, 16'h0000);
        ir = 16'h0080;
        #1;
        check_val("sximm8_sign", sximm8, 16'hFF80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
